// File: rtl/alu_result_collector.sv
// -----------------------------------------------------------------------------
// alu_result_collector
//
// Deframes the 1-bit result stream of the serial ALU. Each frame is
// F = 2n+2 bits: parity bit, zero-flag bit, then the 2n-bit result MSB first.
// The frame flags are checked against the reassembled result, and the word is
// presented on a valid/ready interface. Frames that arrive while the holding
// register is still full are dropped and counted.
//
// There is no frame-sync input. Alignment comes from reset: the first posedge
// after Reset_n is released samples frame bit 0.
//
// Ports
//   Clock           in   system clock (ALU drives on negedge, sampled here on posedge)
//   Reset_n         in   asynchronous active-low reset
//   Serial_in       in   ALU Data_out
//   Out_ready       in   consumer accepts the held word this cycle
//   Out_valid       out  holding register contains a completed frame
//   Out_result      out  reassembled 2n-bit result
//   Out_parity_err  out  frame parity bit != ^result
//   Out_zero_err    out  frame zero bit   != ~|result
//   Drop_count      out  frames lost to backpressure, saturates at 255
//   Frame_active    out  high once the post-reset skip period is over
// -----------------------------------------------------------------------------
module alu_result_collector #(
  parameter int n           = 2,
  parameter int skip_frames = 1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Serial_in,
  input  logic             Out_ready,
  output logic             Out_valid,
  output logic [2*n-1:0]   Out_result,
  output logic             Out_parity_err,
  output logic             Out_zero_err,
  output logic [7:0]       Drop_count,
  output logic             Frame_active
);

  localparam int RW     = 2 * n;
  localparam int F      = RW + 2;
  localparam int CNT_W  = $clog2(F);
  localparam int SKIP_W = (skip_frames > 0) ? $clog2(skip_frames + 1) : 1;

  localparam logic [CNT_W-1:0]  BIT_PAR   = CNT_W'(0);
  localparam logic [CNT_W-1:0]  BIT_ZERO  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(F - 1);
  localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(skip_frames);

  // Saturating increment for the drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [CNT_W-1:0]  bit_cnt_p0;
  logic              par_bit_p0;
  logic              zero_bit_p0;
  logic [RW-1:0]     shift_p0;
  logic [SKIP_W-1:0] skip_cnt;
  logic [SKIP_W-1:0] skip_nxt;

  logic              frame_end;
  logic              skipping;
  logic [RW-1:0]     word_p0;
  logic              par_err;
  logic              zero_err;
  logic              hold_free;

  // ---- stage p0: serial capture (flags + shift register) ----
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      bit_cnt_p0  <= '0;
      par_bit_p0  <= 1'b0;
      zero_bit_p0 <= 1'b0;
      shift_p0    <= '0;
    end else begin
      bit_cnt_p0 <= frame_end ? '0 : bit_cnt_p0 + 1'b1;
      if (bit_cnt_p0 == BIT_PAR) begin
        par_bit_p0 <= Serial_in;
      end else if (bit_cnt_p0 == BIT_ZERO) begin
        zero_bit_p0 <= Serial_in;
      end else begin
        shift_p0 <= {shift_p0[RW-2:0], Serial_in};
      end
    end
  end

  // The last result bit is still on Serial_in at the frame-end edge, so the
  // checks look at the shift register with that bit appended.
  always_comb begin
    frame_end = (bit_cnt_p0 == LAST_BIT);
    skipping  = (skip_cnt != '0);
    word_p0   = {shift_p0[RW-2:0], Serial_in};
    par_err   = par_bit_p0 != (^word_p0);
    zero_err  = zero_bit_p0 != (~|word_p0);
    hold_free = !Out_valid || Out_ready;
    skip_nxt  = skip_cnt;
    if (frame_end && skipping) begin
      skip_nxt = skip_cnt - 1'b1;
    end
  end

  // ---- stage p1: holding register and handshake ----
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      skip_cnt       <= SKIP_INIT;
      Frame_active   <= 1'b0;
      Out_valid      <= 1'b0;
      Out_result     <= '0;
      Out_parity_err <= 1'b0;
      Out_zero_err   <= 1'b0;
      Drop_count     <= '0;
    end else begin
      skip_cnt     <= skip_nxt;
      Frame_active <= (skip_nxt == '0);

      if (Out_valid && Out_ready) begin
        Out_valid <= 1'b0;
      end

      // A frame end overrides the clear above when the word is replaced.
      if (frame_end && !skipping) begin
        if (hold_free) begin
          Out_valid      <= 1'b1;
          Out_result     <= word_p0;
          Out_parity_err <= par_err;
          Out_zero_err   <= zero_err;
        end else begin
          Drop_count <= sat_inc8(Drop_count);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_result_collector.sv
// -----------------------------------------------------------------------------
// tb_alu_result_collector
//
// Drives serial frames the way the ALU does (on negedge) and compares the
// collector's outputs after every posedge with a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_alu_result_collector;

  localparam int N  = 2;
  localparam int RW = 2 * N;
  localparam int F  = RW + 2;

  logic          Clock;
  logic          Reset_n;
  logic          Serial_in;
  logic          Out_ready;
  logic          Out_valid;
  logic [RW-1:0] Out_result;
  logic          Out_parity_err;
  logic          Out_zero_err;
  logic [7:0]    Drop_count;
  logic          Frame_active;

  alu_result_collector #(.n(N), .skip_frames(1)) dut (
    .Clock          (Clock),
    .Reset_n        (Reset_n),
    .Serial_in      (Serial_in),
    .Out_ready      (Out_ready),
    .Out_valid      (Out_valid),
    .Out_result     (Out_result),
    .Out_parity_err (Out_parity_err),
    .Out_zero_err   (Out_zero_err),
    .Drop_count     (Drop_count),
    .Frame_active   (Frame_active)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  // Reference model state (frame-level view).
  logic          m_valid;
  logic [RW-1:0] m_result;
  logic          m_perr;
  logic          m_zerr;
  int            m_drops;
  int            m_skip;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string where);
    check_eq({where, ".valid"}, 32'(Out_valid), 32'(m_valid));
    check_eq({where, ".drop"}, 32'(Drop_count), 32'(m_drops));
    check_eq({where, ".active"}, 32'(Frame_active), 32'(m_skip == 0));
    if (m_valid) begin
      check_eq({where, ".result"}, 32'(Out_result), 32'(m_result));
      check_eq({where, ".perr"}, 32'(Out_parity_err), 32'(m_perr));
      check_eq({where, ".zerr"}, 32'(Out_zero_err), 32'(m_zerr));
    end
  endtask

  task automatic do_reset();
    Reset_n   = 1'b0;
    Serial_in = 1'b0;
    Out_ready = 1'b0;
    m_valid   = 1'b0;
    m_result  = '0;
    m_perr    = 1'b0;
    m_zerr    = 1'b0;
    m_drops   = 0;
    m_skip    = 1;
    #23;
    check_eq("rst.valid", 32'(Out_valid), 32'd0);
    check_eq("rst.result", 32'(Out_result), 32'd0);
    check_eq("rst.perr", 32'(Out_parity_err), 32'd0);
    check_eq("rst.zerr", 32'(Out_zero_err), 32'd0);
    check_eq("rst.drop", 32'(Drop_count), 32'd0);
    check_eq("rst.active", 32'(Frame_active), 32'd0);
    @(posedge Clock);
    #1 Reset_n = 1'b1;
  endtask

  // frame is sent MSB first: frame[F-1] = parity, frame[F-2] = zero flag,
  // frame[RW-1:0] = result. rdy[i] is Out_ready during bit i of the frame.
  task automatic send_bits(input string tag, input logic [F-1:0] frame,
                           input logic [F-1:0] rdy, input int nbits);
    logic [RW-1:0] res;
    logic          free;
    res = frame[RW-1:0];
    for (int i = 0; i < nbits; i++) begin
      @(negedge Clock);
      Serial_in = frame[F-1-i];
      Out_ready = rdy[i];
      @(posedge Clock);
      free = !m_valid || rdy[i];
      if (m_valid && rdy[i]) m_valid = 1'b0;
      if (i == F - 1) begin
        if (m_skip > 0) begin
          m_skip--;
        end else if (free) begin
          m_valid  = 1'b1;
          m_result = res;
          m_perr   = frame[F-1] != (^res);
          m_zerr   = frame[F-2] != (res == 0);
        end else if (m_drops < 255) begin
          m_drops++;
        end
      end
      #1 check_outputs(tag);
    end
  endtask

  task automatic send_frame(input string tag, input logic [F-1:0] frame, input logic [F-1:0] rdy);
    send_bits(tag, frame, rdy, F);
  endtask

  initial begin
    logic [F-1:0] fr;
    logic [F-1:0] rd;

    do_reset();

    // First frame after reset is discarded.
    send_frame("skip", 6'b101101, 6'b111111);
    send_frame("f0110", 6'b000110, 6'b000000);
    check_eq("f0110.res_direct", 32'(Out_result), 32'h6);

    send_frame("f_zero_ok", 6'b010000, 6'b111111);
    send_frame("f_zero_bad", 6'b000000, 6'b111111);
    check_eq("f_zero_bad.zerr_direct", 32'(Out_zero_err), 32'd1);
    send_frame("f_par6", 6'b100110, 6'b111111);
    check_eq("f_par6.perr_direct", 32'(Out_parity_err), 32'd1);
    send_frame("f_par9", 6'b101001, 6'b111111);
    send_frame("f_ok9", 6'b001001, 6'b111111);

    // Backpressure: 6 is held, 9 and 3 are dropped.
    send_frame("bp6", 6'b100110, 6'b011111);
    send_frame("bp9", 6'b001001, 6'b000000);
    send_frame("bp3", 6'b000011, 6'b000000);
    check_eq("bp.drop_direct", 32'(Drop_count), 32'd2);
    check_eq("bp.res_direct", 32'(Out_result), 32'h6);

    // One-cycle ready, then ready only on the frame-end cycle.
    send_frame("pulse", 6'b010000, 6'b000001);
    send_frame("simul", 6'b001001, 6'b100000);
    check_eq("simul.res_direct", 32'(Out_result), 32'h9);

    // Reset three bits into a frame.
    send_bits("partial", 6'b001111, 6'b000000, 3);
    do_reset();
    send_frame("skip2", 6'b110011, 6'b111111);
    send_frame("fF", 6'b001111, 6'b000000);
    check_eq("fF.res_direct", 32'(Out_result), 32'hF);

    // Random frames with random ready patterns.
    for (int k = 0; k < 150; k++) begin
      fr = F'($urandom);
      rd = F'($urandom);
      send_frame("rand", fr, rd);
    end

    // Saturate the drop counter.
    for (int k = 0; k < 260; k++) begin
      fr = F'($urandom);
      send_frame("sat", fr, 6'b000000);
    end
    check_eq("sat.drop_direct", 32'(Drop_count), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
- Downstream neighbour of the serial ALU. It consumes the ALU's 1-bit Data_out stream and deframes each 2n+2-bit result frame: parity bit, zero-flag bit, then 2n result bits MSB first.
- It checks the parity and zero flags against the reassembled result and presents each frame as a parallel word on a valid/ready interface to the host-side logic.
- It tracks frames dropped under backpressure.

Parameters:
- n, 2, operand width of the companion ALU; the result is 2n bits and the frame is F = 2n+2 bits.
- skip_frames, 1, number of frames discarded after reset; the first ALU frame carries undefined 0/0 data.

Ports:
- Clock  input  1  system clock; the ALU drives on negedge, this block samples on posedge.
- Reset_n  input  1  asynchronous, active-low reset.
- Serial_in  input  1  ALU Data_out.
- Out_ready  input  1  consumer accepts the word this cycle.
- Out_valid  output  1  Out_result and the error flags hold a completed frame.
- Out_result  output  2n  reassembled result.
- Out_parity_err  output  1  frame parity bit != ^result.
- Out_zero_err  output  1  frame zero bit != ~|result.
- Drop_count  output  8  frames lost because the holding register was full; saturates at 255.
- Frame_active  output  1  high while a frame is being shifted in after the skip period.

Behaviour:
- All flops use posedge Clock with async clear on Reset_n low.
- Reset values: Out_valid=0, Out_result=0, both error flags=0, Drop_count=0, Frame_active=0, bit counter=0, skip counter=skip_frames.
- Alignment rule: the top level deasserts Reset_n shortly after a rising edge. The next negedge is the ALU's first parity bit, and the following posedge samples frame bit 0. The collector has no sync input; it counts bits from release.
- Bit counter: 0..F-1, wraps F-1 -> 0. It advances every posedge out of reset.
- Sampling map:
  - bit 0: captures parity.
  - bit 1: captures zero flag.
  - bits 2..F-1: shift Serial_in into a 2n-bit shift register, left shift, MSB first.
- Frame end: the posedge where the counter is F-1. The final bit enters the shift register at this edge; error checks use the complete word, so combine the shift register with Serial_in.
- Skip state (skip counter > 0): a frame end decrements the counter and the frame is not presented. Frame_active=0 while skipping.
- Deliver state: at a frame end, if the holding register is free, load Out_result and both error flags and set Out_valid=1 from the next cycle.
  - Holding register free = Out_valid=0, or Out_ready=1 this cycle.
- Handshake:
  - Out_valid stays high, with outputs stable, until sampled with Out_ready=1.
  - A transfer with no simultaneous frame end clears Out_valid.
  - Simultaneous transfer and frame end: the new frame replaces the old one and Out_valid stays 1. No drop.
  - Frame end while Out_valid=1 and Out_ready=0: the new frame is discarded, the holding register is unchanged, and Drop_count increments unless it is already 255.
- Latency: the word is visible one cycle after the posedge that samples its last bit.
- Reset mid-frame: a partial frame is lost and the skip counter reloads. The ALU resets on the same signal, so alignment is restored.
- Width rules: parity is the XOR of all 2n bits; zero check is the NOR of all 2n bits. The capture registers are independent, so error flags do not depend on the previous frame.

Test Plan:
- n=2, skip_frames=1. Release reset, send a 6-bit garbage frame, then stream 0,0,0,1,1,0 -> first frame ignored (Frame_active=0 during it); Out_valid=1 one cycle after the 6th bit; Out_result=4'b0110; both errors=0.
- Stream 0,1,0,0,0,0 -> Out_result=0, Out_zero_err=0, Out_parity_err=0. Stream 0,0,0,0,0,0 -> Out_zero_err=1.
- Stream 1,0,0,1,1,0 -> Out_result=6, Out_parity_err=1. Stream 1,0,1,0,0,1 (result 9, even parity) -> Out_parity_err=1. Stream 0,0,1,0,0,1 -> no errors.
- Hold Out_ready=0 across three frames (results 6, 9, 3) -> Out_result stays 6, Drop_count=2. Raise Out_ready for one cycle -> Out_valid=0 until the next frame end.
- Raise Out_ready exactly on a frame-end cycle while Out_valid=1 -> new result loaded, Out_valid stays 1, Drop_count unchanged.
- Pulse Reset_n low after 3 bits of a frame -> all outputs zero. After release, one frame is skipped again and the next frame 0,0,1,1,1,1 yields Out_result=4'hF, no errors.
